// File: rtl/ekf_stage_driver.sv
// ekf_stage_driver
// Host-side initiator for the EKF-SLAM core stage handshake. One host command
// per stage (predict / new-landmark / update) is latched into the payload
// outputs. The matching stage_val bit is then raised until the core
// handshakes. The driver follows stage_rdy low and back high to detect
// completion. After an update, the four S words streamed on S_data are
// re-emitted with index/last qualifiers.
//
// Ports
//   clk, sys_rst       clock, asynchronous active-low reset
//   cmd_valid/ready    host command handshake (ready only while idle)
//   cmd_stage          one-hot stage select: 001 predict, 010 newlm, 100 update
//   cmd_lk, cmd_lm_num landmark index / landmark count
//   cmd_vlr, cmd_alpha predict velocity / steering angle
//   cmd_rk, cmd_phi    range / bearing measurement
//   stage_val          one-hot stage request to the core
//   stage_rdy          per-stage idle indication from the core
//   l_k .. phi         payload to the core, stable for the whole stage
//   S_data             innovation covariance words from the core
//   s_valid/idx/word/last  captured S stream (idx 0..3 = S00,S01,S10,S11)
//   done, err_tmo, err_cmd one-cycle status pulses
module ekf_stage_driver #(
  parameter int                RSA_DW  = 32,
  parameter int                RSA_AW  = 17,
  parameter int                ROW_LEN = 10,
  parameter int                TMO_W   = 16,
  parameter logic [TMO_W-1:0]  TMO_MAX = 16'hFFFF
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_stage,
  input  logic [ROW_LEN-1:0] cmd_lk,
  input  logic [ROW_LEN-1:0] cmd_lm_num,
  input  logic [RSA_DW-1:0]  cmd_vlr,
  input  logic [RSA_AW-1:0]  cmd_alpha,
  input  logic [RSA_DW-1:0]  cmd_rk,
  input  logic [RSA_AW-1:0]  cmd_phi,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_AW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_AW-1:0]  phi,
  input  logic [RSA_DW-1:0]  S_data,
  output logic               s_valid,
  output logic [1:0]         s_idx,
  output logic [RSA_DW-1:0]  s_word,
  output logic               s_last,
  output logic               done,
  output logic               err_tmo,
  output logic               err_cmd
);

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY_LO, BUSY_HI, CAPTURE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  state_t             state, state_nx;
  logic [2:0]         stage_q;
  logic [2:0]         stage_val_nx;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
  logic [1:0]         cap_cnt, cap_nx;
  logic               load;
  logic               done_nx, err_tmo_nx, err_cmd_nx;
  logic               s_valid_nx, s_last_nx;
  logic [1:0]         s_idx_nx;
  logic [RSA_DW-1:0]  s_word_nx;
  logic               stage_legal, sel_rdy, handshake, tmo_hit;

  assign cmd_ready   = (state == IDLE);
  assign stage_legal = (cmd_stage == 3'b001) || (cmd_stage == 3'b010) ||
                       (cmd_stage == 3'b100);
  // Only the ready bit of the stage in flight matters; the others are ignored.
  assign sel_rdy     = |(stage_q & stage_rdy);
  assign handshake   = |(stage_val & stage_rdy);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx     = state;
    stage_val_nx = stage_val;
    tmo_nx       = tmo_cnt;
    cap_nx       = cap_cnt;
    load         = 1'b0;
    done_nx      = 1'b0;
    err_tmo_nx   = 1'b0;
    err_cmd_nx   = 1'b0;
    s_valid_nx   = 1'b0;
    s_last_nx    = 1'b0;
    s_idx_nx     = s_idx;
    s_word_nx    = s_word;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load = 1'b1;
          if (stage_legal) begin
            state_nx     = LAUNCH;
            stage_val_nx = cmd_stage;
            tmo_nx       = '0;
          end else begin
            err_cmd_nx = 1'b1;
            done_nx    = 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (handshake) begin
          stage_val_nx = '0;
          tmo_nx       = '0;
          state_nx     = BUSY_LO;
        end else if (tmo_hit) begin
          stage_val_nx = '0;
          err_tmo_nx   = 1'b1;
          done_nx      = 1'b1;
          state_nx     = IDLE;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      BUSY_LO: begin
        // Timeout is tested first so the counter can never step past TMO_LAST.
        if (tmo_hit) begin
          err_tmo_nx = 1'b1;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
          if (!sel_rdy) state_nx = BUSY_HI;
        end
      end
      BUSY_HI: begin
        if (sel_rdy) begin
          if (stage_q[2]) begin
            // The completion cycle already carries S00.
            state_nx   = CAPTURE;
            s_valid_nx = 1'b1;
            s_idx_nx   = 2'd0;
            s_word_nx  = S_data;
            cap_nx     = 2'd1;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else if (tmo_hit) begin
          err_tmo_nx = 1'b1;
          done_nx    = 1'b1;
          state_nx   = IDLE;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        s_valid_nx = 1'b1;
        s_idx_nx   = cap_cnt;
        s_word_nx  = S_data;
        cap_nx     = cap_cnt + 1'b1;
        if (cap_cnt == 2'd3) begin
          s_last_nx = 1'b1;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nx;
  end

  // ---- control, payload and output registers ----
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stage_q      <= '0;
      stage_val    <= '0;
      tmo_cnt      <= '0;
      cap_cnt      <= '0;
      l_k          <= '0;
      landmark_num <= '0;
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      s_valid      <= 1'b0;
      s_idx        <= '0;
      s_word       <= '0;
      s_last       <= 1'b0;
      done         <= 1'b0;
      err_tmo      <= 1'b0;
      err_cmd      <= 1'b0;
    end else begin
      stage_val <= stage_val_nx;
      tmo_cnt   <= tmo_nx;
      cap_cnt   <= cap_nx;
      s_valid   <= s_valid_nx;
      s_idx     <= s_idx_nx;
      s_word    <= s_word_nx;
      s_last    <= s_last_nx;
      done      <= done_nx;
      err_tmo   <= err_tmo_nx;
      err_cmd   <= err_cmd_nx;
      if (load) begin
        stage_q      <= cmd_stage;
        l_k          <= cmd_lk;
        landmark_num <= cmd_lm_num;
        vlr          <= cmd_vlr;
        alpha        <= cmd_alpha;
        rk           <= cmd_rk;
        phi          <= cmd_phi;
      end
    end
  end

endmodule

// File: tb/tb_ekf_stage_driver.sv
module tb_ekf_stage_driver;
  localparam int          RSA_DW  = 32;
  localparam int          RSA_AW  = 17;
  localparam int          ROW_LEN = 10;
  localparam int          TMO_W   = 16;
  localparam logic [15:0] TMO_MAX = 16'd100;
  localparam int          TMO_CYC = 100;

  logic               clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_stage = '0;
  logic [ROW_LEN-1:0] cmd_lk = '0;
  logic [ROW_LEN-1:0] cmd_lm_num = '0;
  logic [RSA_DW-1:0]  cmd_vlr = '0;
  logic [RSA_AW-1:0]  cmd_alpha = '0;
  logic [RSA_DW-1:0]  cmd_rk = '0;
  logic [RSA_AW-1:0]  cmd_phi = '0;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy = 3'b111;
  logic [ROW_LEN-1:0] l_k, landmark_num;
  logic [RSA_DW-1:0]  vlr, rk;
  logic [RSA_AW-1:0]  alpha, phi;
  logic [RSA_DW-1:0]  S_data = '0;
  logic               s_valid, s_last, done, err_tmo, err_cmd;
  logic [1:0]         s_idx;
  logic [RSA_DW-1:0]  s_word;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ekf_stage_driver #(
    .RSA_DW(RSA_DW), .RSA_AW(RSA_AW), .ROW_LEN(ROW_LEN),
    .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stage(cmd_stage),
    .cmd_lk(cmd_lk), .cmd_lm_num(cmd_lm_num), .cmd_vlr(cmd_vlr),
    .cmd_alpha(cmd_alpha), .cmd_rk(cmd_rk), .cmd_phi(cmd_phi),
    .stage_val(stage_val), .stage_rdy(stage_rdy),
    .l_k(l_k), .landmark_num(landmark_num), .vlr(vlr), .alpha(alpha),
    .rk(rk), .phi(phi), .S_data(S_data),
    .s_valid(s_valid), .s_idx(s_idx), .s_word(s_word), .s_last(s_last),
    .done(done), .err_tmo(err_tmo), .err_cmd(err_cmd)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cmd_ready, stage_val, done, err_tmo, err_cmd, s_valid, s_last}
  function automatic logic [8:0] ctl();
    return {cmd_ready, stage_val, done, err_tmo, err_cmd, s_valid, s_last};
  endfunction

  function automatic logic [117:0] payload();
    return {l_k, landmark_num, vlr, alpha, rk, phi};
  endfunction

  task automatic scramble_cmd();
    cmd_stage  = 3'($urandom);
    cmd_lk     = 10'($urandom);
    cmd_lm_num = 10'($urandom);
    cmd_vlr    = $urandom;
    cmd_alpha  = 17'($urandom);
    cmd_rk     = $urandom;
    cmd_phi    = 17'($urandom);
  endtask

  // Issue one legal command at the current negedge and act as the core.
  // Expected waveform, indexed by negedge k after the command was offered:
  //   stage_val high for k = 1..h (h = bp+1, handshake cycle)
  //   core busy (selected rdy low) for busy cycles, completes at cycle c
  //   done at c+1 (predict/newlm), S words at c+1..c+4 (update),
  //   or err_tmo+done TMO_CYC cycles after the handshake edge.
  task automatic run_cmd(input logic [2:0] stg, input logic [9:0] lk,
                         input logic [31:0] v, input logic [16:0] a,
                         input logic [31:0] r, input logic [16:0] p,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int bp, input int busy, input bit never,
                         input int abort_k);
    logic [31:0]  w [4];
    logic [9:0]   lmn;
    logic [117:0] exp_pl;
    logic [2:0]   exp_sv;
    logic         upd, r_sel, exp_done, exp_tmo, exp_sval, exp_last, exp_crdy;
    int           sel, h, c, e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    lmn  = 10'($urandom);
    sel  = stg[0] ? 0 : (stg[1] ? 1 : 2);
    upd  = stg[2];
    h    = bp + 1;
    c    = h + busy + 1;
    e    = never ? (h + TMO_CYC + 1) : (upd ? c + 4 : c + 1);
    exp_pl = {lk, lmn, v, a, r, p};

    cmd_valid  = 1'b1;
    cmd_stage  = stg;
    cmd_lk     = lk;
    cmd_lm_num = lmn;
    cmd_vlr    = v;
    cmd_alpha  = a;
    cmd_rk     = r;
    cmd_phi    = p;
    stage_rdy  = 3'($urandom);
    stage_rdy[sel] = (bp == 0);
    S_data     = $urandom;

    for (int k = 1; k <= e + 1; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      scramble_cmd();
      if (k == abort_k) begin
        #2 sys_rst = 1'b0;
        #1;
        chk("rst_ctl", 128'(ctl()), 128'(9'b1_000_00000));
        chk("rst_payload", 128'(payload()), 128'(0));
        chk("rst_s", 128'({s_idx, s_word}), 128'(0));
        @(negedge clk);
        chk("rst_hold_ctl", 128'(ctl()), 128'(9'b1_000_00000));
        sys_rst   = 1'b1;
        stage_rdy = 3'b111;
        @(negedge clk);
        chk("post_rst_ctl", 128'(ctl()), 128'(9'b1_000_00000));
        return;
      end
      exp_sv   = (k <= h) ? stg : 3'b000;
      exp_done = (k == e);
      exp_tmo  = never && (k == e);
      exp_sval = upd && !never && (k >= c + 1) && (k <= c + 4);
      exp_last = exp_sval && (k == c + 4);
      exp_crdy = (k >= e);
      chk("ctl", 128'(ctl()),
          128'({exp_crdy, exp_sv, exp_done, exp_tmo, 1'b0, exp_sval, exp_last}));
      if (exp_sval) begin
        chk("s_idx", 128'(s_idx), 128'(k - c - 1));
        chk("s_word", 128'(s_word), 128'(w[k - c - 1]));
      end
      chk("payload", 128'(payload()), 128'(exp_pl));
      if (k <= bp)     r_sel = 1'b0;
      else if (k == h) r_sel = 1'b1;
      else if (k < c)  r_sel = 1'b0;
      else             r_sel = !never;
      stage_rdy = 3'($urandom);
      stage_rdy[sel] = r_sel;
      S_data = (upd && !never && k >= c && k <= c + 3) ? w[k - c] : $urandom;
    end
    stage_rdy = 3'b111;
  endtask

  task automatic run_illegal(input logic [2:0] stg);
    logic [117:0] exp_pl;
    cmd_valid  = 1'b1;
    cmd_stage  = stg;
    cmd_lk     = 10'($urandom);
    cmd_lm_num = 10'($urandom);
    cmd_vlr    = $urandom;
    cmd_alpha  = 17'($urandom);
    cmd_rk     = $urandom;
    cmd_phi    = 17'($urandom);
    exp_pl = {cmd_lk, cmd_lm_num, cmd_vlr, cmd_alpha, cmd_rk, cmd_phi};
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("illegal_ctl", 128'(ctl()), 128'(9'b1_000_10100));
    chk("illegal_payload", 128'(payload()), 128'(exp_pl));
    @(negedge clk);
    chk("illegal_after", 128'(ctl()), 128'(9'b1_000_00000));
  endtask

  initial begin
    logic [2:0] st;
    #1 sys_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", 128'(ctl()), 128'(9'b1_000_00000));
    chk("reset_payload", 128'(payload()), 128'(0));
    chk("reset_s", 128'({s_idx, s_word}), 128'(0));
    sys_rst = 1'b1;
    @(negedge clk);

    // predict: rdy held 1 cycle, low 20 cycles, then high
    run_cmd(3'b001, 10'($urandom), 32'h0001_0000, 17'h00100, $urandom, 17'($urandom),
            0, 0, 0, 0, 0, 20, 1'b0, 0);
    // update with S capture
    run_cmd(3'b100, 10'd5, $urandom, 17'($urandom), 32'h0002_0000, 17'($urandom),
            32'd11, 32'd22, 32'd33, 32'd44, 0, 7, 1'b0, 0);
    // new-landmark with 50 cycles of launch back-pressure
    run_cmd(3'b010, 10'($urandom), $urandom, 17'($urandom), $urandom, 17'($urandom),
            0, 0, 0, 0, 50, 5, 1'b0, 0);
    // core never completes -> timeout
    run_cmd(3'b001, 10'($urandom), $urandom, 17'($urandom), $urandom, 17'($urandom),
            0, 0, 0, 0, 0, 1, 1'b1, 0);
    // illegal stage encodings
    run_illegal(3'b011);
    run_illegal(3'b000);
    run_illegal(3'b111);
    // reset while the update is busy, then a normal predict
    run_cmd(3'b100, 10'($urandom), $urandom, 17'($urandom), $urandom, 17'($urandom),
            $urandom, $urandom, $urandom, $urandom, 0, 10, 1'b0, 6);
    run_cmd(3'b001, 10'($urandom), $urandom, 17'($urandom), $urandom, 17'($urandom),
            0, 0, 0, 0, 0, 3, 1'b0, 0);
    // randomized legal commands
    for (int i = 0; i < 10; i++) begin
      st = 3'b001 << $urandom_range(2, 0);
      run_cmd(st, 10'($urandom), $urandom, 17'($urandom), $urandom, 17'($urandom),
              $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(5, 0)), int'($urandom_range(15, 1)), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
